// File: rtl/gradient_flow_sequencer_pkg.sv
// Shared types and sizing for the serpentine gradient generator sequencer.
package gradient_ctrl_pkg;

   localparam int N_OUT_DEFAULT = 11;
   localparam int IDX_W         = $clog2(N_OUT_DEFAULT);

   // Run phases: prime both inlets, dwell/sample each outlet, flush with buffer.
   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      DWELL,
      SAMPLE,
      NEXT,
      FLUSH
   } seq_state_e;

   // How the flush was reached; selects the done or aborted pulse on exit.
   typedef enum logic {
      END_ABORT = 1'b0,
      END_DONE  = 1'b1
   } end_status_e;

endpackage

// File: rtl/gradient_flow_sequencer_if.sv
// Host/valve/detector signal bundle; the sequencer is the slave side.
interface gradient_flow_sequencer_if #(
   parameter int N_OUT = 11,
   parameter int CNT_W = 16
);
   import gradient_ctrl_pkg::*;

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] dwell_cycles;
   logic             valve_a;
   logic             valve_b;
   logic [N_OUT-1:0] outlet_sel;
   logic [IDX_W-1:0] outlet_idx;
   logic             sample_req;
   logic             sample_ack;
   logic             busy;
   logic             done;
   logic             aborted;

   modport master (
      output start, abort, dwell_cycles, sample_ack,
      input  valve_a, valve_b, outlet_sel, outlet_idx, sample_req, busy, done, aborted
   );

   modport slave (
      input  start, abort, dwell_cycles, sample_ack,
      output valve_a, valve_b, outlet_sel, outlet_idx, sample_req, busy, done, aborted
   );

endinterface

// File: rtl/flow_cycle_timer.sv
// Phase down-counter: loaded on phase entry, flags the last cycle of the phase.
module flow_cycle_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] count,
   output logic             expired
);

   logic [CNT_W-1:0] remaining;

   // Load wins over counting; the decrement saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= count;
      end else if (enable && remaining != '0) begin
         remaining <= remaining - 1'b1;
      end
   end

   // One count left marks the final cycle; a zero load behaves like a load of one.
   assign expired = (remaining <= CNT_W'(1));

endmodule

// File: rtl/gradient_flow_sequencer.sv
// Prime/scan/flush sequencer for a 2-inlet serpentine gradient generator.
module gradient_flow_sequencer
   import gradient_ctrl_pkg::*;
#(
   parameter int N_OUT        = N_OUT_DEFAULT,
   parameter int CNT_W        = 16,
   parameter int PRIME_CYCLES = 1000,
   parameter int FLUSH_CYCLES = 500
) (
   input logic                      clk,
   input logic                      rst_n,
   gradient_flow_sequencer_if.slave bus
);

   localparam logic [N_OUT-1:0] SEL_ONE    = {{(N_OUT-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_OUT - 1);
   localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_CYCLES);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

   seq_state_e       state;
   end_status_e      end_status;
   logic [CNT_W-1:0] dwell_lat;
   logic             abort_ok;
   logic             tmr_load;
   logic             tmr_en;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_expired;

   assign abort_ok = bus.abort && (state inside {PRIME, DWELL, SAMPLE, NEXT});
   assign tmr_en   = (state inside {PRIME, DWELL, FLUSH});

   flow_cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .enable  (tmr_en),
      .count   (tmr_val),
      .expired (tmr_expired)
   );

   // Reload the shared timer with the length of whichever phase starts next.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      tmr_load = 1'b0;
      tmr_val  = dwell_lat;
      if (abort_ok) begin
         tmr_load = 1'b1;
         tmr_val  = FLUSH_LOAD;
      end else begin
         case (state)
            IDLE: begin
               tmr_load = bus.start;
               tmr_val  = PRIME_LOAD;
            end
            PRIME:   tmr_load = tmr_expired;
            NEXT: begin
               tmr_load = 1'b1;
               tmr_val  = (bus.outlet_idx == LAST_IDX) ? FLUSH_LOAD : dwell_lat;
            end
            default: tmr_load = 1'b0;
         endcase
      end
   end

   // Phase sequencing with every output registered; abort outranks ack and timer expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         end_status     <= END_ABORT;
         dwell_lat      <= '0;
         bus.valve_a    <= 1'b0;
         bus.valve_b    <= 1'b0;
         bus.outlet_sel <= '0;
         bus.outlet_idx <= '0;
         bus.sample_req <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.aborted    <= 1'b0;
      end else begin
         bus.done    <= 1'b0;
         bus.aborted <= 1'b0;
         if (abort_ok) begin
            state          <= FLUSH;
            end_status     <= END_ABORT;
            bus.valve_a    <= 1'b0;
            bus.outlet_sel <= '0;
            bus.sample_req <= 1'b0;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  state       <= PRIME;
                  dwell_lat   <= (bus.dwell_cycles == '0) ? CNT_W'(1) : bus.dwell_cycles;
                  bus.valve_a <= 1'b1;
                  bus.valve_b <= 1'b1;
                  bus.busy    <= 1'b1;
               end
               PRIME: if (tmr_expired) begin
                  state          <= DWELL;
                  bus.outlet_idx <= '0;
                  bus.outlet_sel <= SEL_ONE;
               end
               DWELL: if (tmr_expired) begin
                  state          <= SAMPLE;
                  bus.sample_req <= 1'b1;
               end
               SAMPLE: if (bus.sample_ack && bus.sample_req) begin
                  state          <= NEXT;
                  bus.sample_req <= 1'b0;
                  bus.outlet_sel <= '0;
               end
               NEXT: if (bus.outlet_idx == LAST_IDX) begin
                  state       <= FLUSH;
                  end_status  <= END_DONE;
                  bus.valve_a <= 1'b0;
               end else begin
                  state          <= DWELL;
                  bus.outlet_idx <= bus.outlet_idx + 1'b1;
                  bus.outlet_sel <= SEL_ONE << (bus.outlet_idx + 1'b1);
               end
               FLUSH: if (tmr_expired) begin
                  state       <= IDLE;
                  bus.valve_b <= 1'b0;
                  bus.busy    <= 1'b0;
                  bus.done    <= (end_status == END_DONE);
                  bus.aborted <= (end_status == END_ABORT);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Never two outlets at once, and reagent never flows without buffer.
   a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.outlet_sel));
   a_a_needs_b:  assert property (@(posedge clk) disable iff (!rst_n) bus.valve_a |-> bus.valve_b);

endmodule

// File: tb/tb_gradient_flow_sequencer.sv
// Bench for gradient_flow_sequencer: per-run expected trace built from the phase rules.
module tb_gradient_flow_sequencer;
   import gradient_ctrl_pkg::*;

   localparam int N_OUT = 11;
   localparam int CNT_W = 16;
   localparam int PRIME = 4;
   localparam int FLUSH = 3;

   typedef struct {
      logic [31:0] exp;
      bit          ack;
      bit          abrt;
      bit          strt;
   } step_t;

   logic   clk = 1'b0;
   logic   rst_n;
   step_t  steps[$];
   int     n_pass   = 0;
   int     n_checks = 0;
   int     model_idx = 0;
   int     ack_dly[N_OUT];
   int     ack_pos[N_OUT];

   always #5 clk = ~clk;

   gradient_flow_sequencer_if #(.N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

   gradient_flow_sequencer #(
      .N_OUT(N_OUT), .CNT_W(CNT_W), .PRIME_CYCLES(PRIME), .FLUSH_CYCLES(FLUSH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Output vector layout: va, vb, sel[10:0], idx[3:0], req, busy, done, aborted.
   function automatic logic [31:0] pack(input bit va, input bit vb, input logic [N_OUT-1:0] sel,
                                        input int idx, input bit req, input bit busy,
                                        input bit dn, input bit ab);
      return {11'd0, va, vb, sel, 4'(idx), req, busy, dn, ab};
   endfunction

   function automatic logic [31:0] observe();
      return {11'd0, bus.valve_a, bus.valve_b, bus.outlet_sel, bus.outlet_idx,
              bus.sample_req, bus.busy, bus.done, bus.aborted};
   endfunction

   task automatic push(input logic [31:0] e, input bit a);
      step_t st;
      st.exp = e; st.ack = a; st.abrt = 1'b0; st.strt = 1'b0;
      steps.push_back(st);
   endtask

   // abort_at: -1 none, -2 on the ack cycle of outlet 5, -3 random point in the scan.
   task automatic build(input int d, input int abort_at, input bit noise);
      int eff_d, ab, idx_end, flush_start;
      logic [N_OUT-1:0] s;
      step_t st;
      steps.delete();
      eff_d = (d == 0) ? 1 : d;
      for (int c = 0; c < PRIME; c++) push(pack(1, 1, '0, model_idx, 0, 1, 0, 0), 0);
      for (int i = 0; i < N_OUT; i++) begin
         s = '0;
         s[i] = 1'b1;
         for (int c = 0; c < eff_d; c++) push(pack(1, 1, s, i, 0, 1, 0, 0), 0);
         for (int c = 0; c < ack_dly[i]; c++) push(pack(1, 1, s, i, 1, 1, 0, 0), 0);
         ack_pos[i] = steps.size();
         push(pack(1, 1, s, i, 1, 1, 0, 0), 1);
         push(pack(1, 1, '0, i, 0, 1, 0, 0), 0);
      end
      if (abort_at == -2) ab = ack_pos[5];
      else if (abort_at == -3) ab = int'($urandom_range(0, steps.size() - 1));
      else ab = abort_at;
      if (ab >= 0) begin
         while (steps.size() > ab + 1) void'(steps.pop_back());
         st = steps[ab];
         st.abrt = 1'b1;
         steps[ab] = st;
         idx_end = int'(st.exp[7:4]);
      end else begin
         idx_end = N_OUT - 1;
      end
      flush_start = steps.size();
      for (int c = 0; c < FLUSH; c++) push(pack(0, 1, '0, idx_end, 0, 1, 0, 0), 0);
      push(pack(0, 0, '0, idx_end, 0, 0, ab < 0, ab >= 0), 0);
      push(pack(0, 0, '0, idx_end, 0, 0, 0, 0), 0);
      push(pack(0, 0, '0, idx_end, 0, 0, 0, 0), 0);
      model_idx = idx_end;
      if (noise) begin
         for (int j = 0; j < steps.size(); j++) begin
            st = steps[j];
            if (!st.exp[3] && !st.ack) st.ack = ($urandom_range(0, 3) == 0);
            if (st.exp[2]) st.strt = ($urandom_range(0, 4) == 0);
            if (j >= flush_start && j < flush_start + FLUSH) st.abrt = ($urandom_range(0, 2) == 0);
            steps[j] = st;
         end
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.sample_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_idx = 0;
   endtask

   task automatic run(input int d, input int abort_at, input bit noise, input int reset_at);
      logic [31:0] got;
      bit bad = 1'b0, hit_reset = 1'b0;
      bit pg = 1'b0, pe = 1'b0;
      int rg = 0, re = 0, dg = 0, de = 0;
      build(d, abort_at, noise);
      bus.start = 1'b1;
      bus.dwell_cycles = CNT_W'(d);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.dwell_cycles = CNT_W'($urandom_range(0, 7));
      for (int j = 0; j < steps.size(); j++) begin
         bus.sample_ack = steps[j].ack;
         bus.abort      = steps[j].abrt;
         bus.start      = steps[j].strt;
         @(negedge clk);
         got = observe();
         check($sformatf("trace[%0d]", j), got, steps[j].exp);
         check("onehot_sel", 32'($onehot0(bus.outlet_sel)), 32'd1);
         check("va_implies_vb", 32'(!bus.valve_a || bus.valve_b), 32'd1);
         if (got !== steps[j].exp) bad = 1'b1;
         if (got[3] && !pg) rg++;
         if (steps[j].exp[3] && !pe) re++;
         pg = got[3];
         pe = steps[j].exp[3];
         dg += int'(got[1]);
         de += int'(steps[j].exp[1]);
         if (j == reset_at) begin
            #2 rst_n = 1'b0;
            #1 check("async_reset", observe(), 32'd0);
            hit_reset = 1'b1;
            break;
         end
         if (bad) break;
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0; bus.abort = 1'b0; bus.sample_ack = 1'b0;
      if (bad || hit_reset) begin
         reset_dut();
         @(negedge clk);
         check("post_reset_idle", observe(), 32'd0);
         @(posedge clk);
         #1;
      end else begin
         check("req_pulses", 32'(rg), 32'(re));
         check("done_pulses", 32'(dg), 32'(de));
      end
   endtask

   initial begin
      rst_n = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.sample_ack = 1'b0; bus.dwell_cycles = '0;
      #2 rst_n = 1'b0;
      #1 check("reset_state", observe(), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hold", observe(), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Normal scan, detector acks one cycle after each request.
      for (int i = 0; i < N_OUT; i++) ack_dly[i] = 1;
      run(2, -1, 0, -1);

      // Zero dwell behaves as one cycle per outlet.
      for (int i = 0; i < N_OUT; i++) ack_dly[i] = 0;
      run(0, -1, 0, -1);

      // Abort coinciding with the ack at outlet 5.
      for (int i = 0; i < N_OUT; i++) ack_dly[i] = int'($urandom_range(0, 2));
      run(2, -2, 0, -1);

      // Slow detector at one outlet.
      for (int i = 0; i < N_OUT; i++) ack_dly[i] = 0;
      ack_dly[3] = 20;
      run(1, -1, 0, -1);

      // Reset in the second dwell cycle of outlet 0, then a run with stray start/ack/abort.
      run(3, -1, 0, PRIME + 1);
      for (int i = 0; i < N_OUT; i++) ack_dly[i] = int'($urandom_range(0, 3));
      run(2, -1, 1, -1);

      // Randomised runs.
      for (int r = 0; r < 110 && (n_checks - n_pass) < 20; r++) begin
         for (int i = 0; i < N_OUT; i++)
            ack_dly[i] = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 4));
         run(int'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0) ? -3 : -1, 1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
